// File: rtl/hack_fetch_unit_if.sv
// hack_fetch_unit_if: ROM request/ack bus plus instruction valid/ready and jump redirect bus.
interface hack_fetch_unit_if #(
    parameter int WORD_W = 16,
    parameter int PC_W   = 15
);
    logic              rom_req;
    logic [PC_W-1:0]   rom_addr;
    logic              rom_ack;
    logic [WORD_W-1:0] rom_data;
    logic [WORD_W-1:0] instr;
    logic [PC_W-1:0]   instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump;
    logic [PC_W-1:0]   jump_target;

    modport master (
        output rom_req, rom_addr, instr, instr_pc, instr_valid,
        input  rom_ack, rom_data, instr_ready, jump, jump_target
    );

    modport slave (
        input  rom_req, rom_addr, instr, instr_pc, instr_valid,
        output rom_ack, rom_data, instr_ready, jump, jump_target
    );
endinterface

// File: rtl/hack_fetch_unit.sv
// hack_fetch_unit: HACK CPU fetch stage; PC, ROM req/ack fetch, held instruction with valid/ready, jump redirect.
module hack_fetch_unit #(
    parameter int              WORD_W   = 16,
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    hack_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   ipc_q, ipc_d;
    logic [WORD_W-1:0] instr_q, instr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
        end
    end

    // Jump outranks ack and ready; an ack landing with a jump is dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (bus.jump) begin
            pc_d    = bus.jump_target;
            state_d = FETCH;
        end else if (state_q == FETCH && bus.rom_ack) begin
            instr_d = bus.rom_data;
            ipc_d   = pc_q;
            pc_d    = pc_q + 1'b1;
            state_d = HOLD;
        end else if (state_q == HOLD && bus.instr_ready) begin
            state_d = FETCH;
        end
    end

    assign bus.rom_req     = (state_q == FETCH);
    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
endmodule

// File: tb/tb_hack_fetch_unit.sv
// tb_hack_fetch_unit: directed plan scenarios plus random traffic checked against a transaction-level model.
module tb_hack_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rw_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    hack_fetch_unit_if bus ();
    hack_fetch_unit_if bw ();

    hack_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    hack_fetch_unit #(.RESET_PC(15'h7FFF)) dut_w (.clk(clk), .rst_n(rw_n), .bus(bw));

    always #5 clk = ~clk;

    assign bw.rom_data = {1'b0, bw.rom_addr} ^ 16'hA000;

    // Model: started = out of boot, valid = an instruction is held, else a fetch is outstanding.
    bit m_started, m_valid;
    int m_pc, m_ipc;
    logic [15:0] m_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_valid   = 0;
        m_pc      = 0;
        m_ipc     = 0;
        m_instr   = 16'h0;
    endtask

    task automatic check_all();
        chk("rom_req", 32'(bus.rom_req), 32'(m_started && !m_valid));
        chk("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        chk("instr", 32'(bus.instr), 32'(m_instr));
        chk("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    endtask

    // Drive one cycle of inputs, advance the model, then check at the following negedge.
    task automatic step(input bit ack, input bit rdy, input bit jmp, input int tgt, input logic [15:0] data);
        bus.rom_ack     = ack;
        bus.instr_ready = rdy;
        bus.jump        = jmp;
        bus.jump_target = 15'(tgt);
        bus.rom_data    = data;
        if (rst_n) begin
            if (!m_started) m_started = 1;
            else if (jmp) begin
                m_pc    = tgt;
                m_valid = 0;
            end else if (!m_valid && ack) begin
                m_instr = data;
                m_ipc   = m_pc;
                m_pc    = (m_pc + 1) % 32768;
                m_valid = 1;
            end else if (m_valid && rdy) m_valid = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [15:0] romw();
        return 16'(m_pc) ^ 16'hA000;
    endfunction

    initial begin
        bus.rom_ack = 0; bus.instr_ready = 0; bus.jump = 0; bus.jump_target = '0; bus.rom_data = '0;
        bw.rom_ack = 1; bw.instr_ready = 1; bw.jump = 0; bw.jump_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
        chk("boot_no_req", 32'(bus.rom_req), 32'd0);
        // Zero-wait ROM, ready held high: one instruction per two cycles, ends in FETCH at pc=5.
        repeat (11) step(1, 1, 0, 0, romw());
        chk("zero_wait_pc", 32'(bus.rom_addr), 32'd5);
        // Backpressure at pc=5.
        step(1, 0, 0, 0, romw());
        repeat (4) begin
            step(1, 0, 0, 0, romw());
            chk("bp_instr", 32'(bus.instr), 32'hA005);
            chk("bp_req", 32'(bus.rom_req), 32'd0);
        end
        step(0, 1, 0, 0, romw());
        chk("bp_resume_addr", 32'(bus.rom_addr), 32'd6);
        repeat (4) begin
            step(1, 0, 0, 0, romw());
            step(0, 1, 0, 0, romw());
        end
        // ROM wait states at pc=10.
        repeat (3) begin
            step(0, 1, 0, 0, romw());
            chk("wait_addr", 32'(bus.rom_addr), 32'd10);
        end
        step(1, 1, 0, 0, romw());
        chk("wait_instr", 32'(bus.instr), 32'hA00A);
        step(0, 1, 0, 0, romw());
        repeat (9) begin
            step(1, 0, 0, 0, romw());
            step(0, 1, 0, 0, romw());
        end
        // Jump colliding with ack at pc=20.
        chk("pre_jump_addr", 32'(bus.rom_addr), 32'd20);
        step(1, 1, 1, 32'h100, romw());
        chk("jump_no_valid", 32'(bus.instr_valid), 32'd0);
        step(1, 1, 0, 0, romw());
        chk("jump_ipc", 32'(bus.instr_pc), 32'h100);
        // Random traffic.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'h7FFF : int'($urandom_range(0, 32767)), 16'($urandom));
        // Async reset during FETCH at pc=0x42, between edges.
        step(0, 0, 1, 32'h42, romw());
        #2 rst_n = 1'b0;
        #1 chk("async_req", 32'(bus.rom_req), 32'd0);
        chk("async_valid_f", 32'(bus.instr_valid), 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        step(0, 0, 1, 32'h1234, romw());
        chk("post_rst_addr", 32'(bus.rom_addr), 32'd0);
        // Async reset while holding an instruction.
        step(1, 0, 0, 0, romw());
        #2 rst_n = 1'b0;
        #1 chk("async_valid_h", 32'(bus.instr_valid), 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        // PC wrap on a RESET_PC=0x7FFF instance.
        rw_n = 1'b1;
        chk("w_boot", 32'(bw.rom_req), 32'd0);
        @(negedge clk);
        chk("w_req", 32'(bw.rom_req), 32'd1);
        chk("w_addr", 32'(bw.rom_addr), 32'h7FFF);
        @(negedge clk);
        chk("w_valid", 32'(bw.instr_valid), 32'd1);
        chk("w_ipc", 32'(bw.instr_pc), 32'h7FFF);
        chk("w_instr", 32'(bw.instr), 32'hDFFF);
        @(negedge clk);
        chk("w_wrap_req", 32'(bw.rom_req), 32'd1);
        chk("w_wrap_addr", 32'(bw.rom_addr), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
